// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor.
// Optional feature macro: BP_GSHARE_EN (global-history index hashing).
package branch_predictor_pkg;

  // 2-bit saturating counter states; the MSB is the taken/not-taken guess.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } ctr_e;

  // Every table entry starts weakly not-taken.
  localparam ctr_e BP_CTR_RESET = BP_WNT;

  function automatic logic ctr_predicts_taken(input ctr_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Prediction and resolution signals between the pipeline and the predictor.
// Optional feature macro: BP_GSHARE_EN (does not change this interface).
interface branch_predictor_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic             pred_stall;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output pred_valid, pred_stall, pred_pc,
    output upd_valid, upd_idx, upd_taken, upd_pred_taken,
    input  pred_taken, pred_idx, mispredict, br_cnt, miss_cnt
  );

  modport slave (
    input  pred_valid, pred_stall, pred_pc,
    input  upd_valid, upd_idx, upd_taken, upd_pred_taken,
    output pred_taken, pred_idx, mispredict, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_cnt2.sv
// Next-state logic for one 2-bit saturating branch counter.
// Optional feature macro: BP_GSHARE_EN (not used here).
module sat_cnt2
  import branch_predictor_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e nxt
);

  // Step toward strong-taken on taken, toward strong-not-taken otherwise; stick at the ends.
  always_comb begin
    nxt = cur;
    unique case (cur)
      BP_SNT: nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT: nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:  nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:  nxt = taken ? BP_ST  : BP_WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a register table of 2-bit counters indexed by the
// word-aligned PC, trained on resolution, with statistics counters.
// Optional feature macro: BP_GSHARE_EN hashes the index with a global history.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          resetn,
  branch_predictor_if.slave bp
);

  localparam int DEPTH = 1 << IDX_W;

  ctr_e             table_q [DEPTH];
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic             pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  ctr_e             upd_cur, upd_nxt, pred_ctr;
  logic             mispredict;
  logic             unused_pc;

  assign unused_pc = ^{bp.pred_pc[31:IDX_W+2], bp.pred_pc[1:0]};

  assign upd_cur = table_q[bp.upd_idx];

  sat_cnt2 u_sat_cnt2 (
    .cur   (upd_cur),
    .taken (bp.upd_taken),
    .nxt   (upd_nxt)
  );

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  assign idx_d = bp.pred_pc[IDX_W+1:2] ^ ghr_q;

  // Global history advances in resolution order, newest outcome at the LSB.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ghr_q <= '0;
    end else if (bp.upd_valid) begin
      ghr_q <= {ghr_q[IDX_W-2:0], bp.upd_taken};
    end
  end
`else
  assign idx_d = bp.pred_pc[IDX_W+1:2];
`endif

  assign mispredict = bp.upd_valid & (bp.upd_taken != bp.upd_pred_taken);

  // Prediction sees the counter as it will be after this cycle's update (write-first).
  always_comb begin
    pred_ctr = table_q[idx_d];
    if (bp.upd_valid && (bp.upd_idx == idx_d)) begin
      pred_ctr = upd_nxt;
    end
  end

  // Next prediction registers: hold under stall, otherwise guess only for real branches.
  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (!bp.pred_stall) begin
      pred_idx_d   = idx_d;
      pred_taken_d = bp.pred_valid & ctr_predicts_taken(pred_ctr);
    end
  end

  // Statistics counters stop at all-ones instead of wrapping.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.upd_valid && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispredict && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // Counter table lives in flops so one reset edge returns every entry to weak-NT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= BP_CTR_RESET;
      end
    end else if (bp.upd_valid) begin
      table_q[bp.upd_idx] <= upd_nxt;
    end
  end

  // Prediction outputs and statistics registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bp.pred_taken = pred_taken_q;
  assign bp.pred_idx   = pred_idx_q;
  assign bp.mispredict = mispredict;
  assign bp.br_cnt     = br_cnt_q;
  assign bp.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Optional feature macro: BP_GSHARE_EN (bench follows the same build switch).
module tb_branch_predictor;

  localparam int IDX_W   = 6;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 1 << IDX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] PC0 = 32'h0040_0010;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  branch_predictor_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bpIf ();

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bpIf.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: counter values 0..3 per entry, history as an integer.
  int modelCtr [DEPTH];
  int modelGhr;
  int expPredTaken;
  int expPredIdx;
  int expBr;
  int expMiss;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelIndex(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % DEPTH);
`ifdef BP_GSHARE_EN
    idx = idx ^ modelGhr;
`endif
    return idx;
  endfunction

  // Apply the rules to the inputs the DUT just sampled at the last rising edge.
  task automatic modelAdvance();
    int idx;
    int u;
    if (resetn !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) modelCtr[i] = 1;
      modelGhr     = 0;
      expPredTaken = 0;
      expPredIdx   = 0;
      expBr        = 0;
      expMiss      = 0;
    end else begin
      idx = modelIndex(bpIf.pred_pc);
      if (bpIf.upd_valid) begin
        u = int'(bpIf.upd_idx);
        if (bpIf.upd_taken) modelCtr[u] = (modelCtr[u] == 3) ? 3 : modelCtr[u] + 1;
        else                modelCtr[u] = (modelCtr[u] == 0) ? 0 : modelCtr[u] - 1;
        if (expBr < CNT_MAX) expBr++;
        if ((bpIf.upd_taken != bpIf.upd_pred_taken) && (expMiss < CNT_MAX)) expMiss++;
        modelGhr = (modelGhr * 2 + int'(bpIf.upd_taken)) % DEPTH;
      end
      if (!bpIf.pred_stall) begin
        expPredIdx   = idx;
        expPredTaken = (bpIf.pred_valid && modelCtr[idx] >= 2) ? 1 : 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, then advance the model.
  task automatic applyStimulus(input bit rn, input bit pv, input bit ps, input logic [31:0] pc,
                               input bit uv, input int ui, input bit ut, input bit upt);
    logic [IDX_W-1:0] uiBits;
    uiBits               = IDX_W'(ui);
    resetn               = rn;
    bpIf.pred_valid      = pv;
    bpIf.pred_stall      = ps;
    bpIf.pred_pc         = pc;
    bpIf.upd_valid       = uv;
    bpIf.upd_idx         = uiBits;
    bpIf.upd_taken       = ut;
    bpIf.upd_pred_taken  = upt;
    @(posedge clk);
    #1;
    modelAdvance();
    checkEn = 1'b1;
  endtask

  // Every falling edge: all outputs against the model, mispredict against current inputs.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pred_taken", bpIf.pred_taken, expPredTaken);
      checkOutput("pred_idx",   bpIf.pred_idx,   expPredIdx);
      checkOutput("br_cnt",     bpIf.br_cnt,     expBr);
      checkOutput("miss_cnt",   bpIf.miss_cnt,   expMiss);
      checkOutput("mispredict", bpIf.mispredict,
                  (bpIf.upd_valid && (bpIf.upd_taken != bpIf.upd_pred_taken)) ? 1 : 0);
    end
  end

  initial begin
    logic [31:0] pc;
    int ui;

    resetn              = 1'b0;
    bpIf.pred_valid     = 1'b0;
    bpIf.pred_stall     = 1'b0;
    bpIf.pred_pc        = '0;
    bpIf.upd_valid      = 1'b0;
    bpIf.upd_idx        = '0;
    bpIf.upd_taken      = 1'b0;
    bpIf.upd_pred_taken = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset pred_taken", bpIf.pred_taken, 0);
    checkOutput("reset pred_idx",   bpIf.pred_idx,   0);

`ifndef BP_GSHARE_EN
    $display("[TB] bimodal directed scenarios");
    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("first pred_taken", bpIf.pred_taken, 0);
    checkOutput("first pred_idx",   bpIf.pred_idx,   32'h04);
    checkOutput("first br_cnt",     bpIf.br_cnt,     0);
    checkOutput("first miss_cnt",   bpIf.miss_cnt,   0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, PC0, 1, 4, 1, 0);
    checkOutput("idle pred_taken", bpIf.pred_taken, 0);
    checkOutput("idle pred_idx",   bpIf.pred_idx,   32'h04);
    checkOutput("train br_cnt",    bpIf.br_cnt,     3);
    checkOutput("train miss_cnt",  bpIf.miss_cnt,   3);

    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("strong-T predict", bpIf.pred_taken, 1);

    applyStimulus(1, 1, 0, PC0, 1, 4, 0, 1);
    checkOutput("bypass to weak-T", bpIf.pred_taken, 1);
    applyStimulus(1, 1, 0, PC0, 1, 4, 0, 1);
    checkOutput("bypass to weak-NT", bpIf.pred_taken, 0);
    checkOutput("bypass miss_cnt",   bpIf.miss_cnt,   5);

    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 32'h0040_0100 + 32'(k * 4), (k == 1), 4, 1, 0);
      checkOutput("stall hold taken", bpIf.pred_taken, 0);
      checkOutput("stall hold idx",   bpIf.pred_idx,   32'h04);
    end
    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("update during stall", bpIf.pred_taken, 1);

    for (int i = 0; i < (1 << CNT_W) + 5; i++) applyStimulus(1, 0, 0, 0, 1, i % DEPTH, 1, 0);
    checkOutput("sat br_cnt",   bpIf.br_cnt,   15);
    checkOutput("sat miss_cnt", bpIf.miss_cnt, 15);

    applyStimulus(0, 1, 0, PC0, 1, 4, 1, 0);
    checkOutput("midreset pred_taken", bpIf.pred_taken, 0);
    checkOutput("midreset pred_idx",   bpIf.pred_idx,   0);
    checkOutput("midreset br_cnt",     bpIf.br_cnt,     0);
    checkOutput("midreset miss_cnt",   bpIf.miss_cnt,   0);
    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("midreset ctr not-taken", bpIf.pred_taken, 0);
    applyStimulus(1, 0, 0, PC0, 1, 4, 1, 0);
    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("midreset ctr was weak-NT", bpIf.pred_taken, 1);
`else
    $display("[TB] gshare directed scenarios");
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, PC0, 0, 0, 0, 0);
    checkOutput("gshare pred_idx",   bpIf.pred_idx,   32'h02);
    checkOutput("gshare pred_taken", bpIf.pred_taken, 0);
    checkOutput("gshare br_cnt",     bpIf.br_cnt,     3);
    checkOutput("gshare miss_cnt",   bpIf.miss_cnt,   2);
`endif

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      pc = ($urandom() & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 1) == 1) ui = modelIndex(pc);
      else                           ui = int'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 63) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0,
                    pc,
                    $urandom_range(0, 1) == 1,
                    ui,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
    end

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
